apb_slave_ctrl: RTL and testbench

APB_SLAVE_CTRL -- requirements
Module: apb_slave_ctrl

---
 rtl/apb_bridge_pkg.sv | 15 +
 rtl/apb_addr_check.sv | 19 +
 rtl/apb_slave_ctrl.sv | 104 ++++++++++
 tb/tb_apb_slave_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/apb_bridge_pkg.sv
// Shared types and constants for the APB register-file bridge.
// Used by apb_slave_ctrl and apb_addr_check.
package apb_bridge_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WR_ISSUE,
      RD_ISSUE,
      RESP
   } state_t;

   localparam logic [31:0] REG_MAX_ADDR = 32'h3C;
   localparam int          NUM_REGS     = 16;

endpackage

// File: rtl/apb_addr_check.sv
// Combinational address legality check for the register window.
// Flags addresses above REG_MAX_ADDR or not word aligned.
module apb_addr_check
   import apb_bridge_pkg::*;
#(
   parameter int ADDR_WIDTH = 32
) (
   input  logic [ADDR_WIDTH-1:0] addr,
   output logic                  illegal
);

   localparam logic [ADDR_WIDTH-1:0] MAX_A = ADDR_WIDTH'(REG_MAX_ADDR);

   // out of range or misaligned
   always_comb begin
      illegal = (addr > MAX_A) || (addr[1:0] != 2'b00);
   end

endmodule

// File: rtl/apb_slave_ctrl.sv
// APB slave to register-file bridge, one wait state per transfer.
// Define APB_ADDR_CHECK_EN to reject illegal addresses with PSLVERR.
module apb_slave_ctrl
   import apb_bridge_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int NBYTES     = DATA_WIDTH / 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  PSEL,
   input  logic                  PENABLE,
   input  logic                  PWRITE,
   input  logic [ADDR_WIDTH-1:0] PADDR,
   input  logic [DATA_WIDTH-1:0] PWDATA,
   input  logic [NBYTES-1:0]     PSTRB,
   output logic                  PREADY,
   output logic [DATA_WIDTH-1:0] PRDATA,
   output logic                  PSLVERR,
   output logic [ADDR_WIDTH-1:0] rf_addr,
   output logic                  rf_read_en,
   output logic                  rf_write_en,
   output logic [NBYTES-1:0]     rf_byte_strobe,
   output logic [DATA_WIDTH-1:0] rf_wdata,
   input  logic [DATA_WIDTH-1:0] rf_rdata
);

   state_t state;
   logic   wr_q;
   logic   err_q;
   logic   illegal;
   logic   setup;

`ifdef APB_ADDR_CHECK_EN
   apb_addr_check #(
      .ADDR_WIDTH(ADDR_WIDTH)
   ) u_addr_check (
      .addr    (PADDR),
      .illegal (illegal)
   );
`else
   assign illegal = 1'b0;
`endif

   assign setup = PSEL && !PENABLE;

   // transfer FSM with registered strobes and handshake outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         wr_q           <= 1'b0;
         err_q          <= 1'b0;
         rf_addr        <= '0;
         rf_wdata       <= '0;
         rf_byte_strobe <= '0;
         rf_write_en    <= 1'b0;
         rf_read_en     <= 1'b0;
         PREADY         <= 1'b0;
         PSLVERR        <= 1'b0;
      end else begin
         rf_write_en <= 1'b0;
         rf_read_en  <= 1'b0;
         PREADY      <= 1'b0;
         PSLVERR     <= 1'b0;
         unique case (state)
            IDLE: begin
               if (setup) begin
                  wr_q           <= PWRITE;
                  err_q          <= illegal;
                  rf_addr        <= PADDR;
                  rf_wdata       <= PWDATA;
                  rf_byte_strobe <= PWRITE ? PSTRB : '0;
                  rf_write_en    <= PWRITE && !illegal;
                  rf_read_en     <= !PWRITE && !illegal;
                  state          <= PWRITE ? WR_ISSUE : RD_ISSUE;
               end
            end
            WR_ISSUE, RD_ISSUE: begin
               if (!PSEL) begin
                  state <= IDLE;
               end else begin
                  state   <= RESP;
                  PREADY  <= 1'b1;
                  PSLVERR <= err_q;
               end
            end
            RESP: begin
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // read data only visible during the response of a good read
   always_comb begin
      PRDATA = '0;
      if (state == RESP && !wr_q && !err_q) begin
         PRDATA = rf_rdata;
      end
   end

endmodule

// File: tb/tb_apb_slave_ctrl.sv
// Directed self-checking bench for apb_slave_ctrl.
// Includes a small register-file model driving rf_rdata.
module tb_apb_slave_ctrl;
   import apb_bridge_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        PSEL;
   logic        PENABLE;
   logic        PWRITE;
   logic [31:0] PADDR;
   logic [31:0] PWDATA;
   logic [3:0]  PSTRB;
   logic        PREADY;
   logic [31:0] PRDATA;
   logic        PSLVERR;
   logic [31:0] rf_addr;
   logic        rf_read_en;
   logic        rf_write_en;
   logic [3:0]  rf_byte_strobe;
   logic [31:0] rf_wdata;
   logic [31:0] rf_rdata;

   int total = 0;
   int bad   = 0;

   logic [31:0] mem [16];

   apb_slave_ctrl dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .PSEL           (PSEL),
      .PENABLE        (PENABLE),
      .PWRITE         (PWRITE),
      .PADDR          (PADDR),
      .PWDATA         (PWDATA),
      .PSTRB          (PSTRB),
      .PREADY         (PREADY),
      .PRDATA         (PRDATA),
      .PSLVERR        (PSLVERR),
      .rf_addr        (rf_addr),
      .rf_read_en     (rf_read_en),
      .rf_write_en    (rf_write_en),
      .rf_byte_strobe (rf_byte_strobe),
      .rf_wdata       (rf_wdata),
      .rf_rdata       (rf_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = 32'h0;
      rf_rdata = 32'h0;
   end

   // register file: byte-strobed write, registered read
   always @(posedge clk) begin
      if (rf_write_en) begin
         for (int b = 0; b < 4; b++)
            if (rf_byte_strobe[b])
               mem[rf_addr[5:2]][b*8 +: 8] <= rf_wdata[b*8 +: 8];
      end
      if (rf_read_en) rf_rdata <= mem[rf_addr[5:2]];
   end

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic check_idle_outs(input string nm);
      check({nm, "_wen"}, rf_write_en, 0);
      check({nm, "_ren"}, rf_read_en, 0);
      check({nm, "_rdy"}, PREADY, 0);
      check({nm, "_err"}, PSLVERR, 0);
      check({nm, "_prd"}, PRDATA, 0);
   endtask

   // one full APB transfer: setup, access, access+ready
   task automatic xfer(input logic wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s,
                       input logic [31:0] exp_rd, input logic exp_err);
      @(negedge clk);
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr;
      PADDR = a; PWDATA = d; PSTRB = s;
      check("c1_rdy", PREADY, 0);
      @(negedge clk);
      check("c2_wen", rf_write_en, wr && !exp_err);
      check("c2_ren", rf_read_en, !wr && !exp_err);
      check("c2_addr", rf_addr, a);
      check("c2_strb", rf_byte_strobe, wr ? s : 4'h0);
      if (wr) check("c2_wdata", rf_wdata, d);
      check("c2_rdy", PREADY, 0);
      PENABLE = 1'b1;
      @(negedge clk);
      check("c3_rdy", PREADY, 1);
      check("c3_err", PSLVERR, exp_err);
      check("c3_prd", PRDATA, (wr || exp_err) ? 32'h0 : exp_rd);
      check("c3_wen", rf_write_en, 0);
      check("c3_ren", rf_read_en, 0);
   endtask

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      logic [31:0] exp_rd;
   } vec_t;

   vec_t vecs [8];

   initial begin
      vecs[0] = '{1'b1, 32'h08, 32'hDEADBEEF, 4'hF, 32'h0};
      vecs[1] = '{1'b0, 32'h08, 32'h0,        4'h0, 32'hDEADBEEF};
      vecs[2] = '{1'b1, 32'h04, 32'h0000AB00, 4'h2, 32'h0};
      vecs[3] = '{1'b1, 32'h0C, 32'h00000011, 4'hF, 32'h0};
      vecs[4] = '{1'b0, 32'h04, 32'h0,        4'h0, 32'h0000AB00};
      vecs[5] = '{1'b0, 32'h0C, 32'h0,        4'h0, 32'h00000011};
      vecs[6] = '{1'b1, 32'h04, 32'hFFFFFFFF, 4'h9, 32'h0};
      vecs[7] = '{1'b0, 32'h04, 32'h0,        4'h0, 32'hFF00ABFF};

      PSEL = 0; PENABLE = 0; PWRITE = 0;
      PADDR = 0; PWDATA = 0; PSTRB = 0;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check_idle_outs("rst");
      check("rst_addr", rf_addr, 0);
      rst_n = 1'b1;

      // back-to-back table: one transfer every 3 cycles
      for (int i = 0; i < 8; i++)
         xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata,
              vecs[i].strb, vecs[i].exp_rd, 1'b0);
      @(negedge clk);
      PSEL = 0; PENABLE = 0;
      check_idle_outs("post");

      // access phase with no setup is ignored
      @(negedge clk);
      PSEL = 1; PENABLE = 1; PWRITE = 1;
      PADDR = 32'h08; PWDATA = 32'h0; PSTRB = 4'hF;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_idle_outs("noset");
      end
      PSEL = 0; PENABLE = 0;

      // PSEL dropped during RD_ISSUE aborts the read
      @(negedge clk);
      PSEL = 1; PENABLE = 0; PWRITE = 0; PADDR = 32'h00;
      @(negedge clk);
      check("ab_ren", rf_read_en, 1);
      PSEL = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("ab_rdy", PREADY, 0);
         check("ab_state", dut.state, IDLE);
      end
      xfer(1'b0, 32'h00, 32'h0, 4'h0, 32'h0, 1'b0);
      xfer(1'b0, 32'h08, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);
      @(negedge clk);
      PSEL = 0; PENABLE = 0;

      // reset during WR_ISSUE clears outputs at once, write lost
      @(negedge clk);
      PSEL = 1; PENABLE = 0; PWRITE = 1;
      PADDR = 32'h10; PWDATA = 32'h12345678; PSTRB = 4'hF;
      @(negedge clk);
      check("rs_wen_pre", rf_write_en, 1);
      #1 rst_n = 1'b0;
      #1;
      check_idle_outs("rs");
      check("rs_addr", rf_addr, 0);
      check("rs_wdata", rf_wdata, 0);
      check("rs_strb", rf_byte_strobe, 0);
      PSEL = 0; PENABLE = 0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check_idle_outs("rs_after");
      xfer(1'b0, 32'h10, 32'h0, 4'h0, 32'h0, 1'b0);
      @(negedge clk);
      PSEL = 0; PENABLE = 0;

`ifdef APB_ADDR_CHECK_EN
      // illegal addresses answered with an error, no enables
      xfer(1'b1, 32'h40, 32'hCAFEF00D, 4'hF, 32'h0, 1'b1);
      xfer(1'b0, 32'h06, 32'h0, 4'h0, 32'h0, 1'b1);
      @(negedge clk);
      PSEL = 0; PENABLE = 0;
`endif

      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running want finished");
      $fatal(1, "timeout");
   end

endmodule
